// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned FWD_W = 2;

    typedef enum logic {
        RUN     = 1'b0,
        MEMWAIT = 1'b1
    } state_t;

    localparam logic [FWD_W-1:0] FWD_RF = 2'b00;
    localparam logic [FWD_W-1:0] FWD_WB = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MA = 2'b10;

    // Forward select for one EX operand; MA wins over WB, r0 never forwards.
    function automatic logic [FWD_W-1:0] fwd_sel(
        input logic             regwrite_ma,
        input logic [REG_W-1:0] writereg_ma,
        input logic             regwrite_wb,
        input logic [REG_W-1:0] writereg_wb,
        input logic [REG_W-1:0] src
    );
        logic [FWD_W-1:0] sel;
        sel = FWD_RF;
        if (regwrite_ma && (writereg_ma != '0) && (writereg_ma == src)) begin
            sel = FWD_MA;
        end else if (regwrite_wb && (writereg_wb != '0) && (writereg_wb == src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    // Count up on inc, hold at all-ones.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Forwarding, load-use, memory-wait and redirect control for the 5-stage pipeline.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rs_id,
    input  logic [REG_W-1:0] rt_id,
    input  logic             uses_rt_id,
    input  logic [REG_W-1:0] rs_ex,
    input  logic [REG_W-1:0] rt_ex,
    input  logic             regwrite_ex,
    input  logic             memtoreg_ex,
    input  logic [REG_W-1:0] writereg_ex,
    input  logic [REG_W-1:0] writereg_ma,
    input  logic [REG_W-1:0] writereg_wb,
    input  logic             regwrite_ma,
    input  logic             regwrite_wb,
    input  logic             pcsrc,
    input  logic             jump_ex,
    input  logic             jrcontrol_ex,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             en_if,
    output logic             en_ex,
    output logic             en_ma,
    output logic             en_wb,
    output logic             flush_id,
    output logic             bubble_ex,
    output logic [FWD_W-1:0] fwda,
    output logic [FWD_W-1:0] fwdb,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] loaduse_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned        WAIT_W    = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_stall;
    logic              redirect;
    logic              load_use;
    logic              stall_inc;
    logic              flush_inc;
    logic              loaduse_inc;

    // Hazard conditions; a held redirect is simply the still-frozen EX inputs.
    assign mem_stall = dmem_req & ~dmem_ready;
    assign redirect  = pcsrc | jump_ex | jrcontrol_ex;
    assign load_use  = memtoreg_ex & regwrite_ex & (writereg_ex != '0) &
                       ((writereg_ex == rs_id) | (uses_rt_id & (writereg_ex == rt_id)));

    // Pipeline enables, clears and forward selects; all forced low in reset.
    always_comb begin
        en_if     = 1'b0;
        en_ex     = 1'b0;
        en_ma     = 1'b0;
        en_wb     = 1'b0;
        flush_id  = 1'b0;
        bubble_ex = 1'b0;
        fwda      = FWD_RF;
        fwdb      = FWD_RF;
        if (reset) begin
            fwda = fwd_sel(regwrite_ma, writereg_ma, regwrite_wb, writereg_wb, rs_ex);
            fwdb = fwd_sel(regwrite_ma, writereg_ma, regwrite_wb, writereg_wb, rt_ex);
            if (!mem_stall) begin
                en_if = 1'b1;
                en_ex = 1'b1;
                en_ma = 1'b1;
                en_wb = 1'b1;
                if (redirect) begin
                    flush_id  = 1'b1;
                    bubble_ex = 1'b1;
                end else if (load_use) begin
                    en_if     = 1'b0;
                    bubble_ex = 1'b1;
                end
            end
        end
    end

    // Memory-wait FSM with saturating wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else if (mem_stall) begin
            state <= MEMWAIT;
            if (state == RUN) begin
                wait_cnt <= WAIT_W'(1);
            end else if (wait_cnt != WAIT_LAST) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (wait_cnt == WAIT_LAST) begin
                mem_timeout <= 1'b1;
            end
        end else begin
            state    <= RUN;
            wait_cnt <= '0;
        end
    end

    assign stall_inc   = mem_stall;
    assign flush_inc   = ~mem_stall & redirect;
    assign loaduse_inc = ~mem_stall & ~redirect & load_use;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .q     (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_loaduse_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (loaduse_inc),
        .q     (loaduse_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .q     (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (CNT_W=4, TIMEOUT=4).
module tb_pipe_hazard_ctrl;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [4:0] rs_id;
        logic [4:0] rt_id;
        logic       uses_rt;
        logic [4:0] rs_ex;
        logic [4:0] rt_ex;
        logic       rwex;
        logic       m2r;
        logic [4:0] wex;
        logic       rwma;
        logic [4:0] wma;
        logic       rwwb;
        logic [4:0] wwb;
        logic [2:0] redir;
        logic       req;
        logic       rdy;
        logic [1:0] efa;
        logic [1:0] efb;
        logic       eif;
        logic       een;
        logic       efl;
        logic       ebu;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [4:0] rs_id, rt_id, rs_ex, rt_ex, writereg_ex, writereg_ma, writereg_wb;
    logic       uses_rt_id, regwrite_ex, memtoreg_ex, regwrite_ma, regwrite_wb;
    logic       pcsrc, jump_ex, jrcontrol_ex, dmem_req, dmem_ready;
    logic       en_if, en_ex, en_ma, en_wb, flush_id, bubble_ex, mem_timeout;
    logic [1:0] fwda, fwdb;
    logic [CNT_W-1:0] stall_cnt, loaduse_cnt, flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t tbl [0:16];
    vec_t sb [$];

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .rs_id        (rs_id),
        .rt_id        (rt_id),
        .uses_rt_id   (uses_rt_id),
        .rs_ex        (rs_ex),
        .rt_ex        (rt_ex),
        .regwrite_ex  (regwrite_ex),
        .memtoreg_ex  (memtoreg_ex),
        .writereg_ex  (writereg_ex),
        .writereg_ma  (writereg_ma),
        .writereg_wb  (writereg_wb),
        .regwrite_ma  (regwrite_ma),
        .regwrite_wb  (regwrite_wb),
        .pcsrc        (pcsrc),
        .jump_ex      (jump_ex),
        .jrcontrol_ex (jrcontrol_ex),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .en_if        (en_if),
        .en_ex        (en_ex),
        .en_ma        (en_ma),
        .en_wb        (en_wb),
        .flush_id     (flush_id),
        .bubble_ex    (bubble_ex),
        .fwda         (fwda),
        .fwdb         (fwdb),
        .mem_timeout  (mem_timeout),
        .stall_cnt    (stall_cnt),
        .loaduse_cnt  (loaduse_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance past one rising edge; inputs change and outputs settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs_id = '0; rt_id = '0; uses_rt_id = 1'b0; rs_ex = '0; rt_ex = '0;
        regwrite_ex = 1'b0; memtoreg_ex = 1'b0; writereg_ex = '0;
        regwrite_ma = 1'b0; writereg_ma = '0; regwrite_wb = 1'b0; writereg_wb = '0;
        pcsrc = 1'b0; jump_ex = 1'b0; jrcontrol_ex = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        rs_id = v.rs_id; rt_id = v.rt_id; uses_rt_id = v.uses_rt;
        rs_ex = v.rs_ex; rt_ex = v.rt_ex;
        regwrite_ex = v.rwex; memtoreg_ex = v.m2r; writereg_ex = v.wex;
        regwrite_ma = v.rwma; writereg_ma = v.wma;
        regwrite_wb = v.rwwb; writereg_wb = v.wwb;
        {pcsrc, jump_ex, jrcontrol_ex} = v.redir;
        dmem_req = v.req; dmem_ready = v.rdy;
    endtask

    task automatic check_en(input string name, input logic e_if, input logic e_rest);
        check({name, ".en_if"}, 32'(en_if), 32'(e_if));
        check({name, ".en_ex"}, 32'(en_ex), 32'(e_rest));
        check({name, ".en_ma"}, 32'(en_ma), 32'(e_rest));
        check({name, ".en_wb"}, 32'(en_wb), 32'(e_rest));
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        int m_stall, m_lu, m_flush;
        vec_t e;

        //        rsid   rtid  urt   rsex   rtex  rwex  m2r   wex    rwma  wma    rwwb  wwb    redir   req   rdy   fa     fb     if    en    fl    bu
        tbl[0]  = '{5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'b000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{5'd0, 5'd0, 1'b0, 5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 5'd5, 3'b000, 1'b0, 1'b0, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{5'd0, 5'd0, 1'b0, 5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 3'b000, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 3'b000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{5'd0, 5'd0, 1'b0, 5'd3, 5'd7, 1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b1, 5'd7, 3'b000, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{5'd0, 5'd0, 1'b0, 5'd9, 5'd7, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b1, 5'd7, 3'b000, 1'b0, 1'b0, 2'b10, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{5'd0, 5'd8, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 3'b000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{5'd0, 5'd8, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 3'b000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{5'd8, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 3'b000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{5'd0, 5'd0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'b000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{5'd8, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 3'b000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{5'd0, 5'd8, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 3'b100, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[12] = '{5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'b000, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{5'd0, 5'd8, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 3'b100, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'b000, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'b010, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[16] = '{5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'b001, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1};

        // Reset held two cycles with a memory request and a matching forward.
        clear_inputs();
        reset = 1'b0;
        dmem_req = 1'b1;
        regwrite_ma = 1'b1; writereg_ma = 5'd5; rs_ex = 5'd5;
        tick();
        tick();
        check_en("rst", 1'b0, 1'b0);
        check("rst.flush_id", 32'(flush_id), 32'd0);
        check("rst.bubble_ex", 32'(bubble_ex), 32'd0);
        check("rst.fwda", 32'(fwda), 32'd0);
        check("rst.stall_cnt", 32'(stall_cnt), 32'd0);
        check("rst.loaduse_cnt", 32'(loaduse_cnt), 32'd0);
        check("rst.flush_cnt", 32'(flush_cnt), 32'd0);
        check("rst.mem_timeout", 32'(mem_timeout), 32'd0);
        clear_inputs();
        reset = 1'b1;
        #1;
        check_en("rel", 1'b1, 1'b1);
        tick();

        // Table of combinational vectors, scoreboarded, with a counter model.
        m_stall = 0; m_lu = 0; m_flush = 0;
        for (int i = 0; i < 17; i++) begin
            apply(tbl[i]);
            sb.push_back(tbl[i]);
            #1;
            e = sb.pop_front();
            check($sformatf("v%0d.fwda", i), 32'(fwda), 32'(e.efa));
            check($sformatf("v%0d.fwdb", i), 32'(fwdb), 32'(e.efb));
            check_en($sformatf("v%0d", i), e.eif, e.een);
            check($sformatf("v%0d.flush_id", i), 32'(flush_id), 32'(e.efl));
            check($sformatf("v%0d.bubble_ex", i), 32'(bubble_ex), 32'(e.ebu));
            if (!e.een) m_stall++;
            if (e.efl) m_flush++;
            if (e.ebu && !e.efl) m_lu++;
            tick();
        end
        check("tbl.stall_cnt", 32'(stall_cnt), 32'(m_stall));
        check("tbl.loaduse_cnt", 32'(loaduse_cnt), 32'(m_lu));
        check("tbl.flush_cnt", 32'(flush_cnt), 32'(m_flush));
        check("tbl.mem_timeout", 32'(mem_timeout), 32'd0);

        // Load-use lasts one cycle: next cycle the load has moved on.
        do_reset();
        memtoreg_ex = 1'b1; regwrite_ex = 1'b1; writereg_ex = 5'd8; rt_id = 5'd8; uses_rt_id = 1'b1;
        #1;
        check("lu1.en_if", 32'(en_if), 32'd0);
        check("lu1.bubble_ex", 32'(bubble_ex), 32'd1);
        tick();
        clear_inputs();
        #1;
        check("lu2.en_if", 32'(en_if), 32'd1);
        check("lu2.bubble_ex", 32'(bubble_ex), 32'd0);
        check("lu2.loaduse_cnt", 32'(loaduse_cnt), 32'd1);
        tick();

        // Three-cycle memory wait then ready.
        do_reset();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_en($sformatf("mw%0d", k), 1'b0, 1'b0);
            tick();
        end
        dmem_ready = 1'b1;
        #1;
        check_en("mw3", 1'b1, 1'b1);
        tick();
        clear_inputs();
        check("mw.stall_cnt", 32'(stall_cnt), 32'd3);
        check("mw.mem_timeout", 32'(mem_timeout), 32'd0);

        // Redirect held across a two-cycle wait, applied on ready.
        dmem_req = 1'b1; pcsrc = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            check($sformatf("rw%0d.flush_id", k), 32'(flush_id), 32'd0);
            tick();
        end
        dmem_ready = 1'b1;
        #1;
        check("rw2.flush_id", 32'(flush_id), 32'd1);
        check("rw2.bubble_ex", 32'(bubble_ex), 32'd1);
        check("rw2.en_if", 32'(en_if), 32'd1);
        tick();
        clear_inputs();
        check("rw.stall_cnt", 32'(stall_cnt), 32'd5);
        check("rw.flush_cnt", 32'(flush_cnt), 32'd1);

        // Timeout after TIMEOUT stalled cycles, stall counter saturation, sticky flag.
        do_reset();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("to%0d.mem_timeout", k), 32'(mem_timeout), (k == 4) ? 32'd1 : 32'd0);
        end
        for (int k = 0; k < 16; k++) tick();
        check("sat.stall_cnt", 32'(stall_cnt), 32'(CNT_MAX));
        dmem_ready = 1'b1;
        tick();
        tick();
        check("to.sticky", 32'(mem_timeout), 32'd1);
        check("sat.hold", 32'(stall_cnt), 32'(CNT_MAX));
        reset = 1'b0;
        tick();
        check("to.cleared", 32'(mem_timeout), 32'd0);
        check("to.stall_cnt_rst", 32'(stall_cnt), 32'd0);

        // Reset in the middle of a wait aborts it; counting restarts.
        reset = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_en("mid.rst", 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        check("mid.stall_cnt0", 32'(stall_cnt), 32'd0);
        tick();
        check("mid.stall_cnt1", 32'(stall_cnt), 32'd1);
        check("mid.mem_timeout", 32'(mem_timeout), 32'd0);
        clear_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
